// File: rtl/clk_div_multi.sv
// CHANNELS independent programmable clock dividers; outputs registered, en-to-clk_out latency one edge.
// No backpressure: enable and config changes are deferred to period boundaries so clk_out never glitches.
module clk_div_multi #(
    parameter int CHANNELS  = 4,
    parameter int DIV_WIDTH = 16,
    parameter int RESET_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CHANNELS-1:0]  en,
    input  logic                 cfg_wr,
    input  logic [3:0]           cfg_ch,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [DIV_WIDTH-1:0] cfg_high,
    output logic [CHANNELS-1:0]  clk_out,
    output logic [CHANNELS-1:0]  tick,
    output logic [CHANNELS-1:0]  running,
    output logic [CHANNELS-1:0]  cfg_pending
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] TWO       = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] RST_DIV   = DIV_WIDTH'(RESET_DIV);
    localparam logic [DIV_WIDTH-1:0] RST_HIGH  = DIV_WIDTH'(RESET_DIV / 2);

    // Clamp once at write time so every stored period/high pair is legal.
    logic [DIV_WIDTH-1:0] wr_div;
    logic [DIV_WIDTH-1:0] wr_high;

    always_comb begin
        wr_div = (cfg_div < TWO) ? TWO : cfg_div;
        if (cfg_high == '0) begin
            wr_high = ONE;
        end else if (cfg_high >= wr_div) begin
            wr_high = wr_div - ONE;
        end else begin
            wr_high = cfg_high;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t               st_q, st_d;
        logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
        logic [DIV_WIDTH-1:0] div_q, div_d;
        logic [DIV_WIDTH-1:0] high_q, high_d;
        logic [DIV_WIDTH-1:0] pdiv_q, pdiv_d;
        logic [DIV_WIDTH-1:0] phigh_q, phigh_d;
        logic                 pend_q, pend_d;
        logic                 clk_q, clk_d;
        logic                 tick_q, tick_d;
        logic                 wr;
        logic                 wrap;

        // Out-of-range cfg_ch never matches any generated index.
        assign wr   = cfg_wr && (cfg_ch == 4'(i));
        assign wrap = (cnt_q == div_q - ONE);

        always_comb begin
            st_d    = st_q;
            cnt_d   = cnt_q;
            div_d   = div_q;
            high_d  = high_q;
            pdiv_d  = pdiv_q;
            phigh_d = phigh_q;
            pend_d  = pend_q;

            case (st_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (wr) begin
                        div_d  = wr_div;
                        high_d = wr_high;
                    end
                    if (en[i]) begin
                        st_d = ST_RUN;
                    end
                end
                default: begin
                    if (wrap) begin
                        // Period boundary: a write on this very edge beats any older pending pair.
                        cnt_d  = '0;
                        pend_d = 1'b0;
                        if (wr) begin
                            div_d  = wr_div;
                            high_d = wr_high;
                        end else if (pend_q) begin
                            div_d  = pdiv_q;
                            high_d = phigh_q;
                        end
                        st_d = en[i] ? ST_RUN : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                        if (wr) begin
                            pdiv_d  = wr_div;
                            phigh_d = wr_high;
                            pend_d  = 1'b1;
                        end
                        st_d = en[i] ? ST_RUN : ST_STOPPING;
                    end
                end
            endcase

            clk_d  = (st_d != ST_IDLE) && (cnt_d < high_d);
            tick_d = (st_d == ST_RUN) && (cnt_d == '0);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q    <= ST_IDLE;
                cnt_q   <= '0;
                div_q   <= RST_DIV;
                high_q  <= RST_HIGH;
                pdiv_q  <= '0;
                phigh_q <= '0;
                pend_q  <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                st_q    <= st_d;
                cnt_q   <= cnt_d;
                div_q   <= div_d;
                high_q  <= high_d;
                pdiv_q  <= pdiv_d;
                phigh_q <= phigh_d;
                pend_q  <= pend_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
            end
        end

        assign clk_out[i]     = clk_q;
        assign tick[i]        = tick_q;
        assign running[i]     = (st_q != ST_IDLE);
        assign cfg_pending[i] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus random traffic against a period-level reference model.
module tb_clk_div_multi;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] en = '0;
    logic          cfg_wr = 1'b0;
    logic [3:0]    cfg_ch = '0;
    logic [W-1:0]  cfg_div = '0;
    logic [W-1:0]  cfg_high = '0;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic [CH-1:0] running;
    logic [CH-1:0] cfg_pending;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    clk_div_multi #(.CHANNELS(CH), .DIV_WIDTH(W), .RESET_DIV(RD)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_high(cfg_high), .clk_out(clk_out),
        .tick(tick), .running(running), .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    // Reference model: a channel is either active (inside some period) or not,
    // with its position in the current period and the period/high pair in force.
    int m_act[CH];
    int m_en[CH];
    int m_pos[CH];
    int m_div[CH];
    int m_high[CH];
    int m_pend[CH];
    int m_pdiv[CH];
    int m_phigh[CH];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_act[c] = 0; m_en[c] = 0; m_pos[c] = 0;
            m_div[c] = RD; m_high[c] = RD / 2;
            m_pend[c] = 0; m_pdiv[c] = 0; m_phigh[c] = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            bit w;
            int d, h;
            w = cfg_wr && (int'(cfg_ch) == c);
            d = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
            h = (int'(cfg_high) == 0) ? 1 : ((int'(cfg_high) >= d) ? d - 1 : int'(cfg_high));
            if (m_act[c] == 0) begin
                if (w) begin m_div[c] = d; m_high[c] = h; end
                m_pos[c] = 0;
                if (en[c]) m_act[c] = 1;
            end else if (m_pos[c] == m_div[c] - 1) begin
                if (w) begin
                    m_div[c] = d; m_high[c] = h;
                end else if (m_pend[c] != 0) begin
                    m_div[c] = m_pdiv[c]; m_high[c] = m_phigh[c];
                end
                m_pend[c] = 0;
                m_pos[c]  = 0;
                if (!en[c]) m_act[c] = 0;
            end else begin
                m_pos[c] = m_pos[c] + 1;
                if (w) begin m_pend[c] = 1; m_pdiv[c] = d; m_phigh[c] = h; end
            end
            m_en[c] = int'(en[c]);
        end
    endtask

    function automatic logic [CH-1:0] exp_vec(input int kind);
        logic [CH-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) begin
            case (kind)
                0:       v[c] = (m_act[c] != 0) && (m_pos[c] < m_high[c]);
                1:       v[c] = (m_act[c] != 0) && (m_pos[c] == 0) && (m_en[c] != 0);
                2:       v[c] = (m_act[c] != 0);
                default: v[c] = (m_pend[c] != 0);
            endcase
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check("clk_out", 16'(clk_out), 16'(exp_vec(0)));
        check("tick", 16'(tick), 16'(exp_vec(1)));
        check("running", 16'(running), 16'(exp_vec(2)));
        check("cfg_pending", 16'(cfg_pending), 16'(exp_vec(3)));
        cfg_wr = 1'b0;
    endtask

    task automatic write(input int ch, input int d, input int h);
        cfg_wr   = 1'b1;
        cfg_ch   = 4'(ch);
        cfg_div  = W'(d);
        cfg_high = W'(h);
    endtask

    task automatic align(input int c, input int p);
        for (int k = 0; k < 64 && m_pos[c] != p; k++) step();
    endtask

    initial begin
        logic [3:0] pat4;
        logic [5:0] pat6;
        pat4 = 4'b0011;
        pat6 = 6'b000111;

        // Reset state.
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("rst_clk_out", 16'(clk_out), 16'h0);
        check("rst_tick", 16'(tick), 16'h0);
        check("rst_running", 16'(running), 16'h0);
        check("rst_pending", 16'(cfg_pending), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        step();

        // Channel 0 at defaults: 1,1,0,0 with a tick every fourth cycle.
        en[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("ch0_default_pat", 16'(clk_out[0]), 16'(pat4[k % 4]));
            check("ch0_default_tick", 16'(tick[0]), 16'((k % 4) == 0));
        end

        // Channel 1: high=0 clamps to 1, then div=1/high=7 clamps to 2/1.
        write(1, 5, 0);
        step();
        en[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("ch1_div5_pat", 16'(clk_out[1]), 16'((k % 5) == 0));
        end
        write(1, 1, 7);
        step();
        for (int k = 0; k < 12; k++) step();

        // Channel 0 reconfiguration at cnt=1: pending for two cycles, then 1,1,1,0,0,0.
        align(0, 1);
        write(0, 6, 3);
        step();
        check("ch0_pend_a", 16'(cfg_pending[0]), 16'h1);
        step();
        check("ch0_pend_b", 16'(cfg_pending[0]), 16'h1);
        for (int k = 0; k < 12; k++) begin
            step();
            check("ch0_div6_pat", 16'(clk_out[0]), 16'(pat6[k % 6]));
        end
        check("ch0_pend_clr", 16'(cfg_pending[0]), 16'h0);
        // Two writes before the wrap: last one wins.
        align(0, 1);
        write(0, 6, 3);
        step();
        write(0, 8, 4);
        step();
        for (int k = 0; k < 20; k++) step();

        // Channel 2: stop mid-period, then stop-and-resume.
        en[2] = 1'b1;
        align(2, 1);
        en[2] = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("ch2_stopped", 16'(running[2]), 16'h0);
        en[2] = 1'b1;
        align(2, 1);
        en[2] = 1'b0;
        step();
        en[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("ch2_resumed", 16'(running[2]), 16'h1);
        end

        // All channels with different periods, then a write to a non-existent channel.
        write(0, 2, 1); step();
        write(1, 3, 1); step();
        write(2, 4, 2); step();
        write(3, 5, 2); step();
        en = '1;
        for (int k = 0; k < 20; k++) step();
        write(7, 9, 3);
        step();
        check("bad_ch_pending", 16'(cfg_pending), 16'h0);
        for (int k = 0; k < 10; k++) step();

        // Random enables and writes (including out-of-range channels and illegal values).
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                int idx;
                idx = int'($urandom_range(0, CH - 1));
                en[idx] = ~en[idx];
            end
            if ($urandom_range(0, 3) == 0)
                write(int'($urandom_range(0, 7)), int'($urandom_range(0, 9)), int'($urandom_range(0, 11)));
            step();
        end

        // Asynchronous reset mid-high-phase with a pending write outstanding.
        en = '0;
        for (int k = 0; k < 20; k++) step();
        write(0, 6, 4);
        step();
        en = '1;
        step();
        step();
        write(0, 9, 2);
        step();
        check("pre_rst_high", 16'(clk_out[0]), 16'h1);
        check("pre_rst_pend", 16'(cfg_pending[0]), 16'h1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async_clk_out", 16'(clk_out), 16'h0);
        check("async_tick", 16'(tick), 16'h0);
        check("async_running", 16'(running), 16'h0);
        check("async_pending", 16'(cfg_pending), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check("post_rst_pat", 16'(clk_out[0]), 16'(pat4[k % 4]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Synthesizable, parametrised successor to the behavioural testbench clock generators.
- Derives CHANNELS independent divided clock/strobe outputs from one system clock.
- Each channel has a run-time programmable period and high time.
- Enable/disable and reconfiguration are glitch-free: changes only take effect at period boundaries.
- Used by peripherals (UART, PWM, SPI) needing slow clock enables, and by benches needing synthesizable clock sources.

Parameters:
CHANNELS, 4, number of independent divider channels (1..16)
DIV_WIDTH, 16, width of period/high-time fields
RESET_DIV, 4, period loaded into every channel at reset (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  CHANNELS  per-channel run request
cfg_wr  input  1  configuration write strobe, one cycle
cfg_ch  input  4  target channel index for cfg_wr
cfg_div  input  DIV_WIDTH  requested period in clk cycles
cfg_high  input  DIV_WIDTH  requested high time in clk cycles
clk_out  output  CHANNELS  divided clock per channel, registered
tick  output  CHANNELS  one-cycle pulse coinciding with each clk_out rising period start
running  output  CHANNELS  channel in RUN or STOPPING
cfg_pending  output  CHANNELS  a write is waiting for the period boundary

Behaviour:
- Reset (async, immediate) sets, per channel:
  - state=IDLE, cnt=0
  - div_act=RESET_DIV, high_act=RESET_DIV/2
  - pending cleared
  - all outputs 0
- Clamping at write time (stored values are always legal):
  - div<2 → 2
  - high=0 → 1
  - high≥div → div−1 (uses the clamped div)
- Per-channel FSM states: IDLE, RUN, STOPPING.
- IDLE:
  - en=1 sampled → RUN. After that edge: cnt=0, clk_out=1, tick=1.
  - Latency from en rising to clk_out high is one edge.
- RUN/STOPPING counting, at each edge:
  - If cnt==div_act−1 (wrap edge): cnt←0.
  - Otherwise: cnt←cnt+1.
  - After the edge: clk_out=(cnt<high_act); tick=(cnt==0) && state is RUN.
- RUN with en=0 sampled → STOPPING. The current period completes unchanged.
- STOPPING:
  - At the wrap edge → IDLE, cnt=0, clk_out=0, tick=0.
  - en=1 sampled before the wrap → RUN, output waveform uninterrupted.
- Full periods only: no clk_out pulse is ever shorter than high_act or low time shorter than div_act−high_act.
- Configuration writes:
  - cfg_wr=1 with cfg_ch≥CHANNELS is ignored entirely.
  - Target IDLE: div_act/high_act updated at that edge, cfg_pending stays 0.
  - Target RUN/STOPPING: values stored in pending registers, cfg_pending=1 from the next cycle.
  - At the next wrap edge, pending values are copied to div_act/high_act, cfg_pending clears, and the new period starts with cnt=0 under the new values.
  - A second write before the wrap overwrites pending (last write wins).
  - A write on the wrap edge itself is applied at that wrap: the new period uses it and cfg_pending never rises.
  - A write on the STOPPING→IDLE edge is applied to the active registers directly.
- Channels are fully independent. One write strobe addresses one channel only.
- Reset mid-operation: all outputs go low asynchronously, pending writes are discarded, and the channel restarts from IDLE after reset release.

Test Plan:
- Reset, then en[0]=1 with defaults (div=4, high=2) → clk_out[0] pattern 1,1,0,0 repeating; tick[0] every 4th cycle aligned to rising edge; running[0]=1.
- Channel 1 IDLE, write div=5 high=0, then enable → high clamped to 1: pattern 1,0,0,0,0. Write div=1 high=7 → stored as div=2 high=1: pattern 1,0.
- Channel 0 running div=4; at cnt=1 write div=6 high=3 → cfg_pending[0]=1 for 2 cycles; the current period finishes as 1,1,0,0, then 1,1,1,0,0,0 with no glitch. Second write (div=8 high=4) before the wrap → only div=8 is applied.
- en[2] dropped at cnt=1 of div=4 → period completes (0,0 remaining), then clk_out[2]=0, running[2]=0. Repeat but re-raise en at cnt=2 → waveform continuous, running stays 1.
- All 4 channels enabled with div=2,3,4,5 → each output is independent and correct. Write with cfg_ch=7 → no channel changes.
- Assert rst asynchronously mid-high-phase → clk_out/tick/running drop without waiting for clk. After release with en held high, the channel restarts on the next edge at defaults (cnt=0, clk_out=1).
